// File: rtl/vigna_prefetch_pkg.sv
// rtl/vigna_prefetch_pkg.sv - shared types, defaults and helpers for the prefetch queue
package vigna_prefetch_pkg;

    localparam logic [31:0] VIGNA_CORE_RESET_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/vigna_prefetch_if.sv
// rtl/vigna_prefetch_if.sv - i-bus, execute and redirect signals of the prefetch queue
interface vigna_prefetch_if;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        flushing;

    modport master (
        output i_valid, i_addr, inst_valid, inst, inst_pc, flushing,
        input  i_ready, i_rdata, inst_ready, redir_valid, redir_pc
    );

    modport slave (
        input  i_valid, i_addr, inst_valid, inst, inst_pc, flushing,
        output i_ready, i_rdata, inst_ready, redir_valid, redir_pc
    );
endinterface

// File: rtl/vigna_sync_fifo.sv
// rtl/vigna_sync_fifo.sv - synchronous FIFO with flush, registered head, no write-through bypass
module vigna_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/vigna_prefetch.sv
// rtl/vigna_prefetch.sv - DEPTH-entry instruction prefetch queue with redirect and in-flight discard
module vigna_prefetch
    import vigna_prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = VIGNA_CORE_RESET_ADDR,
    parameter int          DEPTH      = 4
) (
    input  logic               clk,
    input  logic               resetn,
    vigna_prefetch_if.master   bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e  state;
    logic          i_valid_q;
    logic [31:0]   i_addr_q;
    logic [31:0]   target_q;
    logic          flushing_q;

    logic          redir;
    logic [31:0]   redir_target;
    logic          push;
    logic          pop;
    logic          room;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    fetch_entry_t  head;

    assign redir        = bus.redir_valid;
    assign redir_target = word_align(bus.redir_pc);
    assign pop          = !fifo_empty && bus.inst_ready;
    assign push         = bus.i_ready && i_valid_q && (state == ST_REQ) && !redir
                          && (!fifo_full || pop);
    assign count_next   = redir ? '0 : count + CW'(push) - CW'(pop);
    assign room         = (count_next < CW'(DEPTH));

    vigna_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wdata  ({i_addr_q, bus.i_rdata}),
        .pop    (pop),
        .flush  (redir),
        .rdata  (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (count)
    );

    assign bus.i_valid    = i_valid_q;
    assign bus.i_addr     = i_addr_q;
    assign bus.flushing   = flushing_q;
    assign bus.inst_valid = !fifo_empty;
    assign bus.inst       = fifo_empty ? 32'h0 : head.inst;
    assign bus.inst_pc    = fifo_empty ? 32'h0 : head.pc;

    // i_addr must stay put while a request is pending, so a redirect that
    // arrives mid-fetch parks its target until the stale word returns.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            i_valid_q  <= 1'b0;
            i_addr_q   <= RESET_ADDR;
            target_q   <= RESET_ADDR;
            flushing_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (redir) begin
                        i_addr_q  <= redir_target;
                        i_valid_q <= 1'b1;
                        state     <= ST_REQ;
                    end else if (room) begin
                        i_valid_q <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (redir && bus.i_ready) begin
                        i_addr_q <= redir_target;
                    end else if (redir) begin
                        target_q   <= redir_target;
                        flushing_q <= 1'b1;
                        state      <= ST_DISCARD;
                    end else if (bus.i_ready) begin
                        i_addr_q  <= i_addr_q + 32'd4;
                        i_valid_q <= room;
                        state     <= room ? ST_REQ : ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (bus.i_ready) begin
                        i_addr_q   <= redir ? redir_target : target_q;
                        flushing_q <= 1'b0;
                        state      <= ST_REQ;
                    end else if (redir) begin
                        target_q <= redir_target;
                    end
                end
                default: begin
                    i_valid_q  <= 1'b0;
                    flushing_q <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vigna_prefetch.sv
// tb/tb_vigna_prefetch.sv - scoreboard bench for the vigna prefetch queue
module tb_vigna_prefetch;

    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mem_auto;
    logic [31:0] sb_pc[$];

    always #5 clk = ~clk;

    vigna_prefetch_if bus ();

    vigna_prefetch #(
        .RESET_ADDR (32'h0000_0000),
        .DEPTH      (4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3C5A_0F0F;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (mem_auto) begin
            bus.i_ready = bus.i_valid;
            bus.i_rdata = bus.i_valid ? mem_word(bus.i_addr) : 32'h0;
        end
    endtask

    task automatic do_reset();
        resetn          = 1'b0;
        mem_auto        = 1'b0;
        bus.i_ready     = 1'b0;
        bus.i_rdata     = 32'h0;
        bus.inst_ready  = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = 32'h0;
        sb_pc.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus.i_valid, bus.inst_valid, bus.flushing} !== 3'b000)
            $display("FAIL reset_flags got=%b want=000", {bus.i_valid, bus.inst_valid, bus.flushing});
        else n_pass++;
        n_checks++;
        if (bus.i_addr !== 32'h0) $display("FAIL reset_i_addr got=%h want=0", bus.i_addr);
        else n_pass++;
        n_checks++;
        if ({bus.inst, bus.inst_pc} !== 64'h0)
            $display("FAIL reset_inst got=%h/%h want=0/0", bus.inst, bus.inst_pc);
        else n_pass++;
        mem_auto = 1'b1;
        tick();
        n_checks++;
        if ({bus.i_valid, bus.inst_valid} !== 2'b10)
            $display("FAIL first_req got=%b want=10", {bus.i_valid, bus.inst_valid});
        else n_pass++;
        tick();
        n_checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0)
            $display("FAIL first_inst got=%b pc=%h want=1 pc=0", bus.inst_valid, bus.inst_pc);
        else n_pass++;
    endtask

    task automatic test_stream();
        int first_pop = -1, last_pop = -1, pops = 0;
        bit started = 0, dropped = 0;
        logic [31:0] exp;
        do_reset();
        mem_auto = 1'b1;
        bus.inst_ready = 1'b1;
        for (int k = 0; k < 16; k++) sb_pc.push_back(32'(k * 4));
        for (int c = 0; c < 40 && sb_pc.size() > 0; c++) begin
            tick();
            if (bus.i_valid) started = 1;
            else if (started) dropped = 1;
            if (bus.inst_valid && bus.inst_ready) begin
                exp = sb_pc.pop_front();
                n_checks++;
                if (bus.inst_pc !== exp || bus.inst !== mem_word(exp))
                    $display("FAIL stream_data got=%h/%h want=%h/%h", bus.inst_pc, bus.inst, exp, mem_word(exp));
                else n_pass++;
                if (first_pop < 0) first_pop = c;
                last_pop = c;
                pops++;
            end
        end
        n_checks++;
        if (pops != 16 || last_pop - first_pop != 15)
            $display("FAIL stream_rate got pops=%0d span=%0d want 16/15", pops, last_pop - first_pop);
        else n_pass++;
        n_checks++;
        if (dropped) $display("FAIL stream_i_valid got=drop want=steady");
        else n_pass++;
    endtask

    task automatic test_fill();
        int fetches = 0;
        do_reset();
        mem_auto = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.i_valid && bus.i_ready) fetches++;
        end
        n_checks++;
        if (fetches != 4 || bus.i_valid !== 1'b0 || bus.inst_valid !== 1'b1)
            $display("FAIL fill got fetches=%0d i_valid=%b want 4/0", fetches, bus.i_valid);
        else n_pass++;
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        n_checks++;
        if (bus.i_valid !== 1'b1 || bus.i_addr !== 32'h10 || bus.inst_pc !== 32'h4)
            $display("FAIL fill_pop got v=%b addr=%h pc=%h want 1/10/4", bus.i_valid, bus.i_addr, bus.inst_pc);
        else n_pass++;
    endtask

    task automatic test_redirect_pending();
        bit found = 0;
        logic [31:0] exp;
        do_reset();
        mem_auto = 1'b1;
        bus.inst_ready = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (bus.i_valid && bus.i_addr == 32'h8) found = 1;
        end
        n_checks++;
        if (!found) $display("FAIL redir_reach got=timeout want=addr 8");
        else n_pass++;
        mem_auto = 1'b0;
        bus.i_ready = 1'b0;
        bus.redir_valid = 1'b1;
        bus.redir_pc = 32'h100;
        for (int k = 0; k < 3; k++) begin
            tick();
            bus.redir_valid = 1'b0;
            n_checks++;
            if (bus.i_addr !== 32'h8 || {bus.i_valid, bus.flushing, bus.inst_valid} !== 3'b110)
                $display("FAIL redir_hold got addr=%h v/f/iv=%b want 8/110", bus.i_addr,
                         {bus.i_valid, bus.flushing, bus.inst_valid});
            else n_pass++;
        end
        bus.i_ready = 1'b1;
        bus.i_rdata = mem_word(32'h8);
        tick();
        bus.i_ready = 1'b0;
        n_checks++;
        if (bus.i_addr !== 32'h100 || bus.flushing !== 1'b0 || bus.inst_valid !== 1'b0)
            $display("FAIL redir_release got addr=%h f=%b iv=%b want 100/0/0", bus.i_addr, bus.flushing, bus.inst_valid);
        else n_pass++;
        mem_auto = 1'b1;
        sb_pc.push_back(32'h100);
        sb_pc.push_back(32'h104);
        for (int c = 0; c < 20 && sb_pc.size() > 0; c++) begin
            tick();
            if (bus.inst_valid && bus.inst_ready) begin
                exp = sb_pc.pop_front();
                n_checks++;
                if (bus.inst_pc !== exp || bus.inst !== mem_word(exp))
                    $display("FAIL redir_data got=%h/%h want=%h/%h", bus.inst_pc, bus.inst, exp, mem_word(exp));
                else n_pass++;
            end
        end
        n_checks++;
        if (sb_pc.size() != 0) $display("FAIL redir_drain got left=%0d want=0", sb_pc.size());
        else n_pass++;
    endtask

    task automatic test_redir_with_pop();
        logic [31:0] exp;
        do_reset();
        mem_auto = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.i_addr !== 32'h8 || bus.i_ready !== 1'b1)
            $display("FAIL rwp_setup got iv=%b pc=%h addr=%h want 1/0/8", bus.inst_valid, bus.inst_pc, bus.i_addr);
        else n_pass++;
        bus.inst_ready = 1'b1;
        bus.redir_valid = 1'b1;
        bus.redir_pc = 32'h203;
        tick();
        bus.redir_valid = 1'b0;
        n_checks++;
        if (bus.inst_valid !== 1'b0 || bus.i_addr !== 32'h200 || bus.i_valid !== 1'b1 || bus.flushing !== 1'b0)
            $display("FAIL rwp_flush got iv=%b addr=%h v=%b f=%b want 0/200/1/0", bus.inst_valid, bus.i_addr,
                     bus.i_valid, bus.flushing);
        else n_pass++;
        sb_pc.push_back(32'h200);
        sb_pc.push_back(32'h204);
        for (int c = 0; c < 20 && sb_pc.size() > 0; c++) begin
            tick();
            if (bus.inst_valid && bus.inst_ready) begin
                exp = sb_pc.pop_front();
                n_checks++;
                if (bus.inst_pc !== exp || bus.inst !== mem_word(exp))
                    $display("FAIL rwp_data got=%h/%h want=%h/%h", bus.inst_pc, bus.inst, exp, mem_word(exp));
                else n_pass++;
            end
        end
        n_checks++;
        if (sb_pc.size() != 0) $display("FAIL rwp_drain got left=%0d want=0", sb_pc.size());
        else n_pass++;
    endtask

    task automatic test_double_redirect();
        logic [31:0] exp;
        do_reset();
        tick();
        bus.redir_valid = 1'b1;
        bus.redir_pc = 32'h40;
        tick();
        bus.redir_pc = 32'h80;
        tick();
        bus.redir_valid = 1'b0;
        tick();
        n_checks++;
        if (bus.i_addr !== 32'h0 || bus.flushing !== 1'b1)
            $display("FAIL dbl_hold got addr=%h f=%b want 0/1", bus.i_addr, bus.flushing);
        else n_pass++;
        bus.i_ready = 1'b1;
        bus.i_rdata = mem_word(32'h0);
        tick();
        bus.i_ready = 1'b0;
        n_checks++;
        if (bus.i_addr !== 32'h80 || bus.flushing !== 1'b0)
            $display("FAIL dbl_target got addr=%h f=%b want 80/0", bus.i_addr, bus.flushing);
        else n_pass++;
        mem_auto = 1'b1;
        bus.inst_ready = 1'b1;
        sb_pc.push_back(32'h80);
        sb_pc.push_back(32'h84);
        for (int c = 0; c < 20 && sb_pc.size() > 0; c++) begin
            tick();
            if (bus.inst_valid && bus.inst_ready) begin
                exp = sb_pc.pop_front();
                n_checks++;
                if (bus.inst_pc !== exp || bus.inst !== mem_word(exp))
                    $display("FAIL dbl_data got=%h/%h want=%h/%h", bus.inst_pc, bus.inst, exp, mem_word(exp));
                else n_pass++;
            end
        end
        n_checks++;
        if (sb_pc.size() != 0) $display("FAIL dbl_drain got left=%0d want=0", sb_pc.size());
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        do_reset();
        mem_auto = 1'b1;
        bus.inst_ready = 1'b1;
        tick();
        bus.redir_valid = 1'b1;
        bus.redir_pc = 32'hFFFF_FFF8;
        tick();
        bus.redir_valid = 1'b0;
        n_checks++;
        if (bus.i_addr !== 32'hFFFF_FFF8) $display("FAIL wrap_start got=%h want=fffffff8", bus.i_addr);
        else n_pass++;
        sb_pc.push_back(32'hFFFF_FFF8);
        sb_pc.push_back(32'hFFFF_FFFC);
        sb_pc.push_back(32'h0);
        sb_pc.push_back(32'h4);
        for (int c = 0; c < 20 && sb_pc.size() > 0; c++) begin
            tick();
            if (bus.inst_valid && bus.inst_ready) begin
                exp = sb_pc.pop_front();
                n_checks++;
                if (bus.inst_pc !== exp || bus.inst !== mem_word(exp))
                    $display("FAIL wrap_data got=%h/%h want=%h/%h", bus.inst_pc, bus.inst, exp, mem_word(exp));
                else n_pass++;
            end
        end
        n_checks++;
        if (sb_pc.size() != 0) $display("FAIL wrap_drain got left=%0d want=0", sb_pc.size());
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [31:0] exp;
        do_reset();
        mem_auto = 1'b1;
        repeat (8) tick();
        n_checks++;
        if (bus.inst_valid !== 1'b1 || bus.i_valid !== 1'b0)
            $display("FAIL ar_full got iv=%b v=%b want 1/0", bus.inst_valid, bus.i_valid);
        else n_pass++;
        mem_auto = 1'b0;
        bus.i_ready = 1'b0;
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({bus.i_valid, bus.inst_valid, bus.flushing} !== 3'b000 || bus.i_addr !== 32'h0
            || {bus.inst, bus.inst_pc} !== 64'h0)
            $display("FAIL ar_outputs got v/iv/f=%b addr=%h inst=%h pc=%h want 000/0/0/0",
                     {bus.i_valid, bus.inst_valid, bus.flushing}, bus.i_addr, bus.inst, bus.inst_pc);
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        mem_auto = 1'b1;
        bus.inst_ready = 1'b1;
        sb_pc.delete();
        sb_pc.push_back(32'h0);
        sb_pc.push_back(32'h4);
        for (int c = 0; c < 20 && sb_pc.size() > 0; c++) begin
            tick();
            if (bus.inst_valid && bus.inst_ready) begin
                exp = sb_pc.pop_front();
                n_checks++;
                if (bus.inst_pc !== exp || bus.inst !== mem_word(exp))
                    $display("FAIL ar_data got=%h/%h want=%h/%h", bus.inst_pc, bus.inst, exp, mem_word(exp));
                else n_pass++;
            end
        end
        n_checks++;
        if (sb_pc.size() != 0) $display("FAIL ar_drain got left=%0d want=0", sb_pc.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_redirect_pending();
        test_redir_with_pop();
        test_double_redirect();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule

// File: doc/vigna_prefetch.md
Name: vigna_prefetch

Overview:
- Parametrised successor to the core's single-slot fetch logic: a DEPTH-entry instruction prefetch queue that decouples the instruction bus from the execute state machine.
- Issues sequential word fetches on the vigna i-bus (valid/ready) ahead of consumption and presents {pc, inst} pairs to execute through a valid/ready port.
- Supports redirect (jump/branch) with flush and discard of an in-flight fetch, which the single-slot fetcher cannot do.

Parameters:
- RESET_ADDR, `VIGNA_CORE_RESET_ADDR, first fetch address after reset (word aligned).
- DEPTH, 4, queue entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- i_valid  out  1  fetch request; held until i_ready.
- i_ready  in  1  fetch completes this cycle; i_rdata valid.
- i_addr  out  32  fetch address; stable while i_valid.
- i_rdata  in  32  fetched instruction.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  execute consumes head.
- inst  out  32  head instruction.
- inst_pc  out  32  head address.
- redir_valid  in  1  redirect request (one-cycle pulse).
- redir_pc  in  32  redirect target; bits [1:0] ignored (forced 00).
- flushing  out  1  high while a discarded fetch is still outstanding.

Behaviour:
- Reset (async assert, sync release): i_valid=0, i_addr=RESET_ADDR, queue empty, inst_valid=0, inst=0, inst_pc=0, flushing=0, FSM=IDLE.
- Storage: DEPTH x 64b {pc,inst}, read/write pointers of log2(DEPTH) bits, wrapping; count of log2(DEPTH)+1 bits. No combinational bypass: an entry written at edge N is visible on inst/inst_valid from edge N onward (one-cycle fetch-to-output latency).
- Pop: inst_valid && inst_ready. Push: i_ready && i_valid && FSM==REQ && !redir_valid.
- count_next = count + push - pop (0 if redir_valid).
- Request rule: i_valid next = (count_next < DEPTH). One outstanding fetch maximum; the returning word always has a slot.
- FSM:
  - IDLE: i_valid=0. Go to REQ when count_next < DEPTH.
  - REQ: i_valid=1, i_addr fixed.
    - On i_ready without redirect: push, i_addr += 4 (wraps 0xFFFF_FFFC -> 0), stay in REQ if count_next < DEPTH, else go to IDLE.
    - On redir_valid without i_ready: go to DISCARD, latch target, flushing=1.
    - On redir_valid with i_ready: drop the word, i_addr = target, stay in REQ.
  - DISCARD: i_valid stays 1, i_addr unchanged (bus rule). Further redirects overwrite the latched target (last wins). On i_ready: drop the word, i_addr = latched/current target, flushing=0, go to REQ.
- Redirect in IDLE: i_addr = target, queue emptied, go to REQ.
- Redirect same cycle as pop: redirect wins; queue empty next cycle, no error.
- Redirect outranks push for the same edge.
- Queue full with pop: a request may be raised in the same edge (count_next < DEPTH).
- i_rdata is sampled only when i_ready; it is never held combinationally.

Decomposition:
- vigna_conf.vh: VIGNA_CORE_RESET_ADDR default and FSM state encodings (IDLE=0, REQ=1, DISCARD=2) as localparams/defines.
- Sub-module vigna_sync_fifo (WIDTH, DEPTH; push/pop/flush/full/empty/count; async active-low reset). vigna_prefetch holds the FSM, address counter and discard logic.

Test Plan:
- Zero-wait memory (i_ready tied 1 while i_valid), inst_ready=1 -> i_valid stays high, one inst per cycle, inst_pc 0x0,0x4,0x8..., first inst_valid 2 cycles after reset release.
- inst_ready=0, DEPTH=4 -> exactly 4 fetches, i_valid drops, count=4. Then pop once -> i_valid reasserts the same cycle, i_addr=0x10.
- Redirect to 0x100 while a fetch at 0x8 is waiting 3 cycles for i_ready -> i_addr stays 0x8 until ready, flushing=1. The 0x8 word is never presented; next i_addr=0x100 and the first inst_pc after it is 0x100.
- redir_valid coincident with i_ready and pop, queue holding 2 entries -> queue empty next cycle, returned word dropped, next i_addr=redir_pc. redir_pc=0x203 yields i_addr=0x200.
- Two redirects (0x40 then 0x80) during one pending fetch -> only 0x80 fetched. Sequential from 0xFFFF_FFF8 -> addresses 0xFFFF_FFFC, 0x0.
- resetn asserted mid-fetch with the queue full -> outputs return to reset values immediately (asynchronous); after release, fetch restarts at RESET_ADDR.
